// File: rtl/mips_fetch_pkg.sv
// Shared types for the instruction-fetch front end: queue entry layout and
// the redirect drain state.
package mips_fetch_pkg;

  localparam int PC_W   = 16;
  localparam int INST_W = 32;

  typedef struct packed {
    logic [PC_W-1:0]   pc_plus1;
    logic [INST_W-1:0] inst;
  } fq_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fq_state_e;

endpackage

// File: rtl/fq_fifo.sv
// DEPTH-entry circular buffer of fetch entries; pointers carry one extra bit
// so a full queue can be told apart from an empty one.
module fq_fifo
  import mips_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  fq_entry_t wdata,
  input  logic      pop,
  input  logic      clear,
  output fq_entry_t rdata,
  output logic [AW:0] count,
  output logic      full,
  output logic      empty
);

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;
  fq_entry_t   mem [DEPTH];

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // NOTE: non-blocking assignments so every flop samples the pre-edge values,
  // independent of the order the always blocks are evaluated in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: storage is deliberately not reset; stale words are never visible
  // because the top zeroes the dequeue outputs whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues credit-limited
// requests, queues in-order responses and flushes on redirect.
// Optional same-cycle response bypass when built with FQ_BYPASS_EN defined.
module fetch_queue
  import mips_fetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  localparam int             CW       = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [PC_W-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              deq_ready,
  output logic              deq_valid,
  output logic [INST_W-1:0] deq_inst,
  output logic [PC_W-1:0]   deq_pc_plus1,
  output logic [CW-1:0]     outstanding
);

  fq_state_e       state;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   fifo_count;
  logic [CW-1:0]   rsp_left;
  logic [CW:0]     credits_used;
  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] rsp_pc;
  logic            live;
  logic            draining;
  logic            req_fire;
  logic            rsp_keep;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  fq_entry_t       head;
  fq_entry_t       tail;

  // Credits cover queued entries plus every in-flight request, including
  // those whose responses will be dropped, so the queue can never overflow.
  assign credits_used   = {1'b0, fifo_count} + {1'b0, outstanding};
  assign imem_req_valid = live && !redirect_valid && (credits_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign draining = (state == DRAIN);
  assign rsp_keep = imem_rsp_valid && !redirect_valid && !draining;
  assign rsp_left = outstanding - CW'(imem_rsp_valid);
  assign pop      = !fifo_empty && deq_ready && !redirect_valid;
  assign tail     = '{pc_plus1: rsp_pc + PC_W'(1), inst: imem_rsp_data};

`ifdef FQ_BYPASS_EN
  logic bypass;
  assign bypass       = rsp_keep && fifo_empty;
  assign push         = rsp_keep && !fifo_full && !(bypass && deq_ready);
  assign deq_valid    = !fifo_empty || bypass;
  assign deq_inst     = !fifo_empty ? head.inst     : (bypass ? tail.inst     : '0);
  assign deq_pc_plus1 = !fifo_empty ? head.pc_plus1 : (bypass ? tail.pc_plus1 : '0);
`else
  assign push         = rsp_keep && !fifo_full;
  assign deq_valid    = !fifo_empty;
  assign deq_inst     = fifo_empty ? '0 : head.inst;
  assign deq_pc_plus1 = fifo_empty ? '0 : head.pc_plus1;
`endif

  fq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (tail),
    .pop   (pop),
    .clear (redirect_valid),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      drop_cnt    <= '0;
      outstanding <= '0;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      live        <= 1'b0;
    end else begin
      live        <= 1'b1;
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        rsp_pc   <= redirect_pc;
        drop_cnt <= rsp_left;
        state    <= (rsp_left != '0) ? DRAIN : RUN;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + PC_W'(1);
        if (rsp_keep) rsp_pc   <= rsp_pc + PC_W'(1);
        if (imem_rsp_valid && draining) begin
          drop_cnt <= drop_cnt - CW'(1);
          if (drop_cnt == CW'(1)) state <= RUN;
        end
      end
    end
  end

endmodule
